// File: rtl/fsm_job_sched.sv
// Round-robin scheduler sharing one byte-stream engine among NREQ requesters.
// Streams each latched job word into the engine and recovers it via a watchdog reset.
module fsm_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [32*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [7:0]             eng_data_in,
  output logic                   eng_rst_n,
  input  logic [7:0]             eng_data_out,
  input  logic                   eng_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, RUN, RESP, RECOVER} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST_ID  = 3'(NREQ - 1);

  state_t      state_q;
  logic [2:0]  ptr_q;
  logic [2:0]  id_q;
  logic [1:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [31:0] job_q;

  logic [NREQ-1:0] gnt_q;
  logic            rsp_valid_q;
  logic [2:0]      rsp_id_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic            eng_start_q;
  logic [7:0]      eng_data_in_q;
  logic            eng_rst_n_q;

  logic            pick_vld_d;
  logic [2:0]      pick_id_d;
  logic [7:0]      pick_oh_d;
  logic [7:0]      req_pad_d;
  logic [3:0]      cand_d;
  logic [31:0]     job_sel_d;

  function automatic logic [7:0] job_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Scanning downward lets the nearest set bit at or after the pointer win.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_id_d  = '0;
    pick_oh_d  = '0;
    cand_d     = '0;
    req_pad_d  = 8'(req);
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand_d = {1'b0, ptr_q} + 4'(j);
      if (cand_d >= 4'(NREQ)) cand_d = cand_d - 4'(NREQ);
      if (req_pad_d[cand_d[2:0]]) begin
        pick_vld_d = 1'b1;
        pick_id_d  = cand_d[2:0];
      end
    end
    if (pick_vld_d) pick_oh_d[pick_id_d] = 1'b1;
  end

  always_comb begin
    job_sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id_d == 3'(i)) job_sel_d = req_data[32*i +: 32];
    end
  end

  // Job word is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && pick_vld_d) job_q <= job_sel_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_data_in_q <= '0;
      eng_rst_n_q   <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_rst_n_q <= 1'b1;
      case (state_q)
        IDLE: begin
          eng_data_in_q <= '0;
          if (pick_vld_d) begin
            gnt_q   <= pick_oh_d[NREQ-1:0];
            id_q    <= pick_id_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start_q   <= 1'b1;
          eng_data_in_q <= job_byte(job_q, 2'd0);
          idx_q         <= 2'd1;
          cnt_q         <= '0;
          busy_q        <= 1'b1;
          state_q       <= RUN;
        end
        RUN: begin
          eng_data_in_q <= job_byte(job_q, idx_q);
          idx_q         <= idx_q + 2'd1;
          cnt_q         <= cnt_q + 8'd1;
          // Done is tested first so it wins a tie with the watchdog.
          if (eng_done) begin
            rsp_data_q <= eng_data_out;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= RECOVER;
          end
        end
        RECOVER: begin
          eng_rst_n_q   <= 1'b0;
          eng_data_in_q <= '0;
          rsp_data_q    <= '0;
          rsp_err_q     <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          busy_q      <= 1'b0;
          ptr_q       <= (id_q == LAST_ID) ? 3'd0 : id_q + 3'd1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign eng_start   = eng_start_q;
  assign eng_data_in = eng_data_in_q;
  assign eng_rst_n   = eng_rst_n_q;

endmodule

// File: tb/tb_fsm_job_sched.sv
// Bench for fsm_job_sched: behavioural engine model plus a grant/response scoreboard.
module tb_fsm_job_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                rsp_valid;
  logic [2:0]          rsp_id;
  logic [7:0]          rsp_data;
  logic                rsp_err;
  logic                busy;
  logic                eng_start;
  logic [7:0]          eng_data_in;
  logic                eng_rst_n;
  logic [7:0]          eng_data_out = 8'h00;
  logic                eng_done = 1'b0;

  fsm_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .eng_start(eng_start), .eng_data_in(eng_data_in), .eng_rst_n(eng_rst_n),
    .eng_data_out(eng_data_out), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  int   total = 0;
  int   bad = 0;
  int   done_at = 6;
  logic busy_prev = 1'b0;
  rsp_t mon_r;
  logic [NREQ-1:0] mon_oh;

  localparam logic [7:0] EXP_B [7] = '{8'h80, 8'h01, 8'h0A, 8'h00, 8'h80, 8'h01, 8'h0A};

  // Engine model: start samples byte0; done comes done_at edges later with data_out=byte2,
  // unless byte1 bit0 is clear (error loop) or byte0 bit7 is clear and byte4 is zero (wait loop).
  logic [7:0] seen [5];
  int  ek = 0;
  bit  active = 1'b0;
  always @(posedge clk) begin
    if (eng_rst_n === 1'b0) begin
      active = 1'b0;
      ek = 0;
      eng_done <= 1'b0;
      eng_data_out <= 8'h00;
    end else begin
      eng_done <= 1'b0;
      if (eng_start === 1'b1) begin
        active = 1'b1;
        ek = 1;
        seen[0] = eng_data_in;
      end else if (active) begin
        ek++;
        if (ek <= 5) seen[ek-1] = eng_data_in;
        if (ek == done_at) begin
          if (seen[1][0] && !(!seen[0][7] && seen[4] == 8'h00)) begin
            eng_done <= 1'b1;
            eng_data_out <= seen[2];
            active = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: grants and responses are popped and compared as they appear.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (gnt !== '0) begin
        total++;
        if (exp_gnt.size() == 0) begin
          bad++;
          $display("FAIL gnt_unexpected got=%b required=none", gnt);
        end else begin
          mon_oh = '0;
          mon_oh[exp_gnt.pop_front()] = 1'b1;
          if (gnt !== mon_oh) begin
            bad++;
            $display("FAIL gnt_order got=%b required=%b", gnt, mon_oh);
          end
        end
        total++;
        if (busy_prev !== 1'b0) begin
          bad++;
          $display("FAIL busy_overlap got busy_prev=%b required=0", busy_prev);
        end
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (exp_rsp.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got id=%0d data=%h err=%b required none", rsp_id, rsp_data, rsp_err);
        end else begin
          mon_r = exp_rsp.pop_front();
          if ({rsp_id, rsp_data, rsp_err} !== mon_r) begin
            bad++;
            $display("FAIL rsp got id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                     rsp_id, rsp_data, rsp_err, mon_r.id, mon_r.data, mon_r.err);
          end
        end
      end
    end
    busy_prev = busy;
  end

  task automatic push_job(input int id, input logic [31:0] w, input logic [7:0] d, input logic e);
    req_data[32*id +: 32] = w;
    exp_gnt.push_back(id);
    exp_rsp.push_back({3'(id), d, e});
  endtask

  task automatic serve(input int ngnt, input bit clear_on_gnt);
    int got = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        got++;
        if (clear_on_gnt) req = req & ~gnt;
        if (got == ngnt) req = '0;
      end
      if (exp_gnt.size() == 0 && exp_rsp.size() == 0) break;
    end
    total++;
    if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL serve_timeout pending gnt=%0d rsp=%0d required 0 0", exp_gnt.size(), exp_rsp.size());
      exp_gnt.delete();
      exp_rsp.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_data_in} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b v=%b id=%0d d=%h e=%b busy=%b st=%b din=%h required all 0",
               gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_data_in);
    end
    total++;
    if (eng_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_eng_rst_n got=%b required=0", eng_rst_n);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (eng_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL release_eng_rst_n got=%b required=1", eng_rst_n);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NREQ; i++) push_job(i, 32'h000A0180, 8'h0A, 1'b0);
    push_job(0, 32'h000A0180, 8'h0A, 1'b0);
    req = '1;
    serve(5, 1'b0);
  endtask

  task automatic test_basic();
    int n = 0;
    push_job(0, 32'h000A0180, 8'h0A, 1'b0);
    req[0] = 1'b1;
    while (gnt[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req[0] = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_at_gnt got=%b required=1", busy); end
    @(negedge clk);
    total++;
    if (eng_start !== 1'b1) begin bad++; $display("FAIL eng_start got=%b required=1", eng_start); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (eng_data_in !== EXP_B[i]) begin
        bad++;
        $display("FAIL byte_stream[%0d] got=%h required=%h", i, eng_data_in, EXP_B[i]);
      end
      total++;
      if (eng_done !== (i == 6)) begin
        bad++;
        $display("FAIL done_timing[%0d] got=%b required=%b", i, eng_done, (i == 6));
      end
      if (i < 6) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_early got=%b required=0", rsp_valid); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rsp_latency got valid=%b busy=%b required valid=1 busy=0", rsp_valid, busy);
    end
    serve(0, 1'b1);
  endtask

  task automatic test_timeout();
    int n = 0;
    push_job(0, 32'h00000000, 8'h00, 1'b1);
    req[0] = 1'b1;
    while (gnt[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req[0] = 1'b0;
    n = 0;
    while (eng_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (eng_rst_n !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (n !== TIMEOUT + 1) begin
      bad++;
      $display("FAIL recover_delay got=%0d required=%0d", n, TIMEOUT + 1);
    end
    @(negedge clk);
    total++;
    if (eng_rst_n !== 1'b1 || rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL recover_pulse got rst_n=%b valid=%b required rst_n=1 valid=1", eng_rst_n, rsp_valid);
    end
    serve(0, 1'b1);
    push_job(0, 32'h000A0180, 8'h0A, 1'b0);
    req[0] = 1'b1;
    serve(1, 1'b1);
  endtask

  task automatic test_wrap();
    push_job(1, 32'h000A0180, 8'h0A, 1'b0);
    req[1] = 1'b1;
    serve(1, 1'b1);
    push_job(0, 32'h000A0180, 8'h0A, 1'b0);
    push_job(1, 32'h000A0180, 8'h0A, 1'b0);
    req = 4'b0011;
    serve(2, 1'b1);
  endtask

  task automatic test_wait_loop();
    push_job(0, 32'h000A0100, 8'h00, 1'b1);
    req[0] = 1'b1;
    serve(1, 1'b1);
    push_job(2, 32'h001A0180, 8'h1A, 1'b0);
    req[2] = 1'b1;
    serve(1, 1'b1);
  endtask

  task automatic test_coincide();
    done_at = TIMEOUT - 1;
    push_job(0, 32'h000A0180, 8'h0A, 1'b0);
    req[0] = 1'b1;
    serve(1, 1'b1);
    done_at = TIMEOUT;
    push_job(0, 32'h000A0180, 8'h00, 1'b1);
    req[0] = 1'b1;
    serve(1, 1'b1);
    done_at = 6;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    req_data[31:0]  = 32'h000A0180;
    req_data[63:32] = 32'h000A0180;
    exp_gnt.push_back(0);
    req[0] = 1'b1;
    while (gnt[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req[0] = 1'b0;
    req[1] = 1'b1;
    n = 0;
    while (eng_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_data_in, eng_rst_n} !== '0) begin
      bad++;
      $display("FAIL midjob_reset got busy=%b st=%b din=%h rst_n=%b v=%b required all 0",
               busy, eng_start, eng_data_in, eng_rst_n, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    push_job(1, 32'h000A0180, 8'h0A, 1'b0);
    serve(1, 1'b1);
  endtask

  initial begin
    req = '0;
    req_data = '0;
    #1;
    test_reset();
    test_round_robin();
    test_basic();
    test_timeout();
    test_wrap();
    test_wait_loop();
    test_coincide();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
